// File: rtl/sky130_ajc_ip__brownout_pkg.sv
// Shared state encoding and default cycle counts for the multi-channel brown-out sequencer.
package sky130_ajc_ip__brownout_pkg;

  localparam int unsigned STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_OFF   = STATE_W'(0);
  localparam state_t ST_ARMED = STATE_W'(1);
  localparam state_t ST_FILT  = STATE_W'(2);
  localparam state_t ST_TRIP  = STATE_W'(3);
  localparam state_t ST_HOLD  = STATE_W'(4);

  localparam int unsigned DEF_NCH               = 2;
  localparam int unsigned DEF_FILT_W            = 4;
  localparam int unsigned DEF_FILT_CYCLES       = 8;
  localparam int unsigned DEF_HOLD_W            = 16;
  localparam int unsigned DEF_HOLD_CYCLES       = 50000;
  localparam int unsigned DEF_SHORT_HOLD_CYCLES = 16;
  localparam int unsigned DEF_CNT_W             = 8;

  // A channel is busy while it is filtering, tripped or holding.
  function automatic logic state_busy(input state_t st);
    return (st == ST_FILT) || (st == ST_TRIP) || (st == ST_HOLD);
  endfunction

endpackage

// File: rtl/sky130_ajc_ip__brownout_chan.sv
// One brown-out channel: 2-flop synchroniser, deglitch filter, hold one-shot.
// Optional per-channel event counter under BROWNOUT_EVENT_CNT_EN.
module sky130_ajc_ip__brownout_chan
  import sky130_ajc_ip__brownout_pkg::*;
#(
  parameter int unsigned FILT_W            = DEF_FILT_W,
  parameter int unsigned FILT_CYCLES       = DEF_FILT_CYCLES,
  parameter int unsigned HOLD_W            = DEF_HOLD_W,
  parameter int unsigned HOLD_CYCLES       = DEF_HOLD_CYCLES,
  parameter int unsigned SHORT_HOLD_CYCLES = DEF_SHORT_HOLD_CYCLES
`ifdef BROWNOUT_EVENT_CNT_EN
  ,
  parameter int unsigned CNT_W             = DEF_CNT_W
`endif
) (
  input  logic             osc_ck,
  input  logic             rst,
  input  logic             active,
  input  logic             force_short_oneshot,
  input  logic             dcomp,
`ifdef BROWNOUT_EVENT_CNT_EN
  input  logic             evt_clr,
  output logic [CNT_W-1:0] evt_cnt,
`endif
  output logic             brout_filt,
  output logic             out,
  output logic             timed_out,
  output logic             busy
);

  if (FILT_CYCLES < 1 || 64'(FILT_CYCLES) >= (64'(1) << FILT_W)) begin : g_bad_filt
    $error("FILT_CYCLES out of range for FILT_W");
  end
  if (HOLD_CYCLES < 1 || 64'(HOLD_CYCLES) > (64'(1) << HOLD_W)) begin : g_bad_hold
    $error("HOLD_CYCLES out of range for HOLD_W");
  end
  if (SHORT_HOLD_CYCLES < 1 || 64'(SHORT_HOLD_CYCLES) > (64'(1) << HOLD_W)) begin : g_bad_short
    $error("SHORT_HOLD_CYCLES out of range for HOLD_W");
  end

  localparam logic [FILT_W-1:0] FILT_LAST  = FILT_W'(FILT_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] SHORT_LOAD = HOLD_W'(SHORT_HOLD_CYCLES - 1);

  logic [1:0]        sync_q;
  logic              dsync;
  state_t            state_q, state_d;
  logic [FILT_W-1:0] filt_q, filt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              timed_q, timed_d;

  assign dsync = sync_q[1];

  always_ff @(posedge osc_ck or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], dcomp};
  end

  always_ff @(posedge osc_ck or posedge rst) begin
    if (rst) begin
      state_q <= ST_OFF;
      filt_q  <= '0;
      hold_q  <= '0;
      timed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      filt_q  <= filt_d;
      hold_q  <= hold_d;
      timed_q <= timed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    filt_d  = filt_q;
    hold_d  = hold_q;
    timed_d = 1'b0;
    if (!active) begin
      state_d = ST_OFF;
      filt_d  = '0;
      hold_d  = '0;
    end else begin
      case (state_q)
        ST_OFF: state_d = ST_ARMED;
        ST_ARMED: begin
          if (dsync) begin
            if (FILT_CYCLES == 1) begin
              state_d = ST_TRIP;
            end else begin
              state_d = ST_FILT;
              filt_d  = FILT_W'(1);
            end
          end
        end
        ST_FILT: begin
          if (!dsync) begin
            state_d = ST_ARMED;
            filt_d  = '0;
          end else if (filt_q >= FILT_LAST) begin
            state_d = ST_TRIP;
            filt_d  = '0;
          end else begin
            filt_d  = filt_q + FILT_W'(1);
          end
        end
        ST_TRIP: begin
          if (!dsync) begin
            state_d = ST_HOLD;
            hold_d  = force_short_oneshot ? SHORT_LOAD : HOLD_LOAD;
          end
        end
        ST_HOLD: begin
          // Re-trigger takes priority over expiry.
          if (dsync) begin
            state_d = ST_TRIP;
            hold_d  = '0;
          end else if (hold_q == '0) begin
            state_d = ST_ARMED;
            timed_d = 1'b1;
          end else begin
            hold_d  = hold_q - HOLD_W'(1);
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  assign out        = (state_q == ST_TRIP) || (state_q == ST_HOLD);
  assign brout_filt = out;
  assign timed_out  = timed_q;
  assign busy       = state_busy(state_q);

`ifdef BROWNOUT_EVENT_CNT_EN
  // Counts fresh brown-out declarations only; HOLD->TRIP re-triggers are excluded.
  logic             trip_evt;
  logic [CNT_W-1:0] evt_q;

  assign trip_evt = (state_d == ST_TRIP) && (state_q != ST_TRIP) && (state_q != ST_HOLD);

  always_ff @(posedge osc_ck or posedge rst) begin
    if (rst)                         evt_q <= '0;
    else if (evt_clr)                evt_q <= '0;
    else if (trip_evt && evt_q != '1) evt_q <= evt_q + CNT_W'(1);
  end

  assign evt_cnt = evt_q;
`endif

endmodule

// File: rtl/sky130_ajc_ip__brownout_seq_multi.sv
// Multi-channel brown-out sequencer top: NCH channels plus aggregate flags.
// Optional event counters under BROWNOUT_EVENT_CNT_EN.
module sky130_ajc_ip__brownout_seq_multi
  import sky130_ajc_ip__brownout_pkg::*;
#(
  parameter int unsigned NCH               = DEF_NCH,
  parameter int unsigned FILT_W            = DEF_FILT_W,
  parameter int unsigned FILT_CYCLES       = DEF_FILT_CYCLES,
  parameter int unsigned HOLD_W            = DEF_HOLD_W,
  parameter int unsigned HOLD_CYCLES       = DEF_HOLD_CYCLES,
  parameter int unsigned SHORT_HOLD_CYCLES = DEF_SHORT_HOLD_CYCLES
`ifdef BROWNOUT_EVENT_CNT_EN
  ,
  parameter int unsigned CNT_W             = DEF_CNT_W
`endif
) (
  input  logic                 osc_ck,
  input  logic                 rst,
`ifdef BROWNOUT_EVENT_CNT_EN
  input  logic                 evt_clr,
  output logic [NCH*CNT_W-1:0] evt_cnt,
`endif
  input  logic                 ena,
  input  logic [NCH-1:0]       ch_en,
  input  logic                 force_short_oneshot,
  input  logic [NCH-1:0]       dcomp,
  output logic [NCH-1:0]       brout_filt,
  output logic [NCH-1:0]       out,
  output logic                 out_any,
  output logic [NCH-1:0]       timed_out,
  output logic                 busy
);

  logic [NCH-1:0] ch_busy;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    sky130_ajc_ip__brownout_chan #(
      .FILT_W            (FILT_W),
      .FILT_CYCLES       (FILT_CYCLES),
      .HOLD_W            (HOLD_W),
      .HOLD_CYCLES       (HOLD_CYCLES),
      .SHORT_HOLD_CYCLES (SHORT_HOLD_CYCLES)
`ifdef BROWNOUT_EVENT_CNT_EN
      ,
      .CNT_W             (CNT_W)
`endif
    ) u_chan (
      .osc_ck              (osc_ck),
      .rst                 (rst),
      .active              (ena & ch_en[i]),
      .force_short_oneshot (force_short_oneshot),
      .dcomp               (dcomp[i]),
`ifdef BROWNOUT_EVENT_CNT_EN
      .evt_clr             (evt_clr),
      .evt_cnt             (evt_cnt[i*CNT_W +: CNT_W]),
`endif
      .brout_filt          (brout_filt[i]),
      .out                 (out[i]),
      .timed_out           (timed_out[i]),
      .busy                (ch_busy[i])
    );
  end

  assign out_any = |out;
  assign busy    = |ch_busy;

endmodule

// File: tb/tb_sky130_ajc_ip__brownout_seq_multi.sv
// Bench for the multi-channel brown-out sequencer: directed table, corner sequences, random vs model.
module tb_sky130_ajc_ip__brownout_seq_multi;

  localparam int NCH     = 2;
  localparam int FILT    = 8;
  localparam int HOLD_L  = 40;
  localparam int SHORT_L = 16;

  logic           osc_ck = 1'b0;
  logic           rst = 1'b0;
  logic           ena, force_short_oneshot, evt_clr;
  logic [NCH-1:0] ch_en, dcomp;
  logic [NCH-1:0] brout_filt, out, timed_out;
  logic           out_any, busy;
`ifdef BROWNOUT_EVENT_CNT_EN
  logic [NCH*8-1:0] evt_cnt;
`endif

  sky130_ajc_ip__brownout_seq_multi #(.NCH(NCH), .HOLD_CYCLES(HOLD_L)) dut (
    .osc_ck              (osc_ck),
    .rst                 (rst),
`ifdef BROWNOUT_EVENT_CNT_EN
    .evt_clr             (evt_clr),
    .evt_cnt             (evt_cnt),
`endif
    .ena                 (ena),
    .ch_en               (ch_en),
    .force_short_oneshot (force_short_oneshot),
    .dcomp               (dcomp),
    .brout_filt          (brout_filt),
    .out                 (out),
    .out_any             (out_any),
    .timed_out           (timed_out),
    .busy                (busy)
  );

  always #5 osc_ck = ~osc_ck;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
  endtask

  // Reference model: brown-out is declared after FILT consecutive synchronised highs
  // and released after (selected length + 1) consecutive synchronised lows.
  logic m_d1[NCH], m_d2[NCH], m_live[NCH], m_brown[NCH], m_pulse[NCH];
  int   m_run[NCH], m_low[NCH], m_lsel[NCH], m_evt[NCH];

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_d1[i] = 0; m_d2[i] = 0; m_live[i] = 0; m_brown[i] = 0; m_pulse[i] = 0;
      m_run[i] = 0; m_low[i] = 0; m_lsel[i] = SHORT_L; m_evt[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < NCH; i++) begin
      logic act, ds, trip;
      act = ena & ch_en[i];
      ds = m_d2[i];
      trip = 0;
      m_pulse[i] = 0;
      if (!act) begin
        m_live[i] = 0; m_brown[i] = 0; m_run[i] = 0; m_low[i] = 0;
      end else if (!m_live[i]) begin
        m_live[i] = 1;
      end else if (m_brown[i]) begin
        if (ds) m_low[i] = 0;
        else begin
          m_low[i]++;
          if (m_low[i] == 1) m_lsel[i] = force_short_oneshot ? SHORT_L : HOLD_L;
          if (m_low[i] == m_lsel[i] + 1) begin
            m_brown[i] = 0; m_pulse[i] = 1; m_low[i] = 0;
          end
        end
      end else if (ds) begin
        m_run[i]++;
        if (m_run[i] == FILT) begin
          m_brown[i] = 1; m_run[i] = 0; trip = 1;
        end
      end else begin
        m_run[i] = 0;
      end
      if (evt_clr) m_evt[i] = 0;
      else if (trip && m_evt[i] < 255) m_evt[i]++;
      m_d2[i] = m_d1[i];
      m_d1[i] = dcomp[i];
    end
  endtask

  task automatic check_model();
    logic [NCH-1:0] e_out, e_to;
    logic e_busy;
    e_busy = 0;
    for (int i = 0; i < NCH; i++) begin
      e_out[i] = m_brown[i];
      e_to[i]  = m_pulse[i];
      e_busy  |= m_live[i] && (m_brown[i] || m_run[i] > 0);
    end
    check("model", 64'({out, brout_filt, timed_out, out_any, busy}),
          64'({e_out, e_out, e_to, |e_out, e_busy}));
`ifdef BROWNOUT_EVENT_CNT_EN
    begin
      logic [NCH*8-1:0] e_evt;
      for (int i = 0; i < NCH; i++) e_evt[i*8 +: 8] = 8'(m_evt[i]);
      check("evt_model", 64'(evt_cnt), 64'(e_evt));
    end
`endif
  endtask

  task automatic tick();
    @(posedge osc_ck);
    #1;
    model_step();
    check_model();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  typedef struct {
    logic           ena;
    logic [NCH-1:0] ch_en;
    logic [NCH-1:0] dcomp;
    int             n;
    logic [NCH-1:0] e_out;
    logic [NCH-1:0] e_to;
    logic           e_busy;
  } vec_t;

  function automatic vec_t mk(input logic e, input logic [1:0] c, input logic [1:0] d,
                              input int n, input logic [1:0] eo, input logic [1:0] et,
                              input logic eb);
    vec_t v;
    v.ena = e; v.ch_en = c; v.dcomp = d; v.n = n;
    v.e_out = eo; v.e_to = et; v.e_busy = eb;
    return v;
  endfunction

  initial begin
    vec_t vecs[13];
    logic any_to;

    vecs[0]  = mk(1, 2'b11, 2'b00,  2, 2'b00, 2'b00, 0);
    vecs[1]  = mk(1, 2'b11, 2'b01,  9, 2'b00, 2'b00, 1);
    vecs[2]  = mk(1, 2'b11, 2'b00,  1, 2'b01, 2'b00, 1);
    vecs[3]  = mk(1, 2'b11, 2'b00, 17, 2'b01, 2'b00, 1);
    vecs[4]  = mk(1, 2'b11, 2'b00,  1, 2'b00, 2'b01, 0);
    vecs[5]  = mk(1, 2'b11, 2'b00,  1, 2'b00, 2'b00, 0);
    vecs[6]  = mk(1, 2'b11, 2'b01,  5, 2'b00, 2'b00, 1);
    vecs[7]  = mk(1, 2'b11, 2'b00,  5, 2'b00, 2'b00, 0);
    vecs[8]  = mk(1, 2'b11, 2'b10, 12, 2'b10, 2'b00, 1);
    vecs[9]  = mk(1, 2'b01, 2'b10,  1, 2'b00, 2'b00, 0);
    vecs[10] = mk(1, 2'b11, 2'b00,  4, 2'b00, 2'b00, 0);
    vecs[11] = mk(0, 2'b11, 2'b11,  3, 2'b00, 2'b00, 0);
    vecs[12] = mk(1, 2'b11, 2'b00,  4, 2'b00, 2'b00, 0);

    ena = 0; ch_en = '0; dcomp = '0; force_short_oneshot = 1; evt_clr = 0;
    model_reset();
    #1 rst = 1;
    #2 check("reset_outputs", 64'({out, brout_filt, timed_out, out_any, busy}), 64'(0));
    repeat (2) @(posedge osc_ck);
    #1 rst = 0;

    for (int v = 0; v < 13; v++) begin
      ena = vecs[v].ena; ch_en = vecs[v].ch_en; dcomp = vecs[v].dcomp;
      ticks(vecs[v].n);
      check($sformatf("vec%0d", v), 64'({out, timed_out, busy}),
            64'({vecs[v].e_out, vecs[v].e_to, vecs[v].e_busy}));
    end

    // Re-trigger at hold cycle 10, then a full short hold after the second release.
    dcomp = 2'b01; ticks(12);
    dcomp = 2'b00; any_to = 0;
    for (int k = 0; k < 10; k++) begin tick(); any_to |= timed_out[0]; end
    dcomp = 2'b01;
    for (int k = 0; k < 5; k++) begin tick(); any_to |= timed_out[0]; end
    check("retrig_no_pulse", 64'(any_to), 64'(0));
    check("retrig_out_high", 64'(out), 64'(2'b01));
    dcomp = 2'b00; ticks(18);
    check("retrig_hold_end_minus1", 64'({out, timed_out}), 64'({2'b01, 2'b00}));
    tick();
    check("retrig_hold_end", 64'({out, timed_out}), 64'({2'b00, 2'b01}));

    // Re-trigger in the very cycle the one-shot would expire.
    dcomp = 2'b01; ticks(12);
    dcomp = 2'b00; ticks(16);
    dcomp = 2'b01; ticks(3);
    check("retrig_at_expiry", 64'({out, timed_out}), 64'({2'b01, 2'b00}));
    dcomp = 2'b00; ticks(19);
    check("expiry_after_retrig", 64'({out, timed_out}), 64'({2'b00, 2'b01}));

    // Hold length latched at HOLD entry: long hold survives a mid-hold switch to short.
    force_short_oneshot = 0;
    dcomp = 2'b01; ticks(12);
    dcomp = 2'b00; ticks(5);
    force_short_oneshot = 1; ticks(37);
    check("long_hold_minus1", 64'({out, timed_out}), 64'({2'b01, 2'b00}));
    tick();
    check("long_hold_end", 64'({out, timed_out}), 64'({2'b00, 2'b01}));

    // Channel disable mid-HOLD: out drops next cycle with no pulse.
    dcomp = 2'b01; ticks(12);
    dcomp = 2'b00; ticks(6);
    ch_en = 2'b10; tick();
    check("disable_mid_hold", 64'({out, timed_out}), 64'(0));
    any_to = 0;
    for (int k = 0; k < 20; k++) begin tick(); any_to |= timed_out[0]; end
    check("disable_no_pulse", 64'(any_to), 64'(0));
    ch_en = 2'b11; ticks(3);

    // Asynchronous reset while both channels are tripped.
    dcomp = 2'b11; ticks(12);
    check("both_tripped", 64'({out, out_any}), 64'({2'b11, 1'b1}));
    #2 rst = 1;
    #1 check("reset_mid_trip", 64'({out, brout_filt, timed_out, out_any, busy}), 64'(0));
    model_reset();
    dcomp = 2'b00;
    @(posedge osc_ck);
    #1 rst = 0;
    ticks(3);

`ifdef BROWNOUT_EVENT_CNT_EN
    // Three brown-outs on channel 1, then a clear coinciding with the fourth trip.
    for (int b = 0; b < 3; b++) begin
      dcomp = 2'b10; ticks(12);
      dcomp = 2'b00; ticks(20);
    end
    check("evt_three", 64'(evt_cnt[15:8]), 64'(3));
    dcomp = 2'b10; ticks(9);
    evt_clr = 1; tick();
    evt_clr = 0;
    check("evt_clr_wins", 64'({out[1], evt_cnt[15:8]}), 64'({1'b1, 8'd0}));
    dcomp = 2'b00; ticks(20);
`endif

    // Random phase with slowly varying inputs so full brown-out cycles occur.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NCH; i++)
        if ($urandom_range(0, 15) == 0) dcomp[i] = ~dcomp[i];
      if ($urandom_range(0, 299) == 0) ena = ~ena;
      if ($urandom_range(0, 249) == 0) ch_en[$urandom_range(0, NCH-1)] ^= 1'b1;
      if ($urandom_range(0, 63) == 0) force_short_oneshot = ~force_short_oneshot;
      evt_clr = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
